// File: rtl/multicycle_control_fsm_pkg.sv
// control_pkg: shared constants for the multicycle RV32I control FSM.
//   - state encodings (4-bit, exported on state_out)
//   - RV32I major opcodes
//   - ALU_control operation codes and the ALU-op class seen by alu_decoder
//   - datapath select codes (ALU source A/B, result source, immediate format)
//   - branch condition evaluation helper
package control_pkg;

    localparam logic [3:0] S_FETCH     = 4'd0;
    localparam logic [3:0] S_DECODE    = 4'd1;
    localparam logic [3:0] S_MEMADR    = 4'd2;
    localparam logic [3:0] S_MEMREAD   = 4'd3;
    localparam logic [3:0] S_MEMWB     = 4'd4;
    localparam logic [3:0] S_MEMWRITE  = 4'd5;
    localparam logic [3:0] S_EXEC_R    = 4'd6;
    localparam logic [3:0] S_ALUWB     = 4'd7;
    localparam logic [3:0] S_EXEC_I    = 4'd8;
    localparam logic [3:0] S_JAL       = 4'd9;
    localparam logic [3:0] S_BRANCH    = 4'd10;
    localparam logic [3:0] S_EXEC_JALR = 4'd11;
    localparam logic [3:0] S_LUI       = 4'd12;
    localparam logic [3:0] S_AUIPC     = 4'd13;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    localparam logic [3:0] ALU_ADD   = 4'd0;
    localparam logic [3:0] ALU_SUB   = 4'd1;
    localparam logic [3:0] ALU_AND   = 4'd2;
    localparam logic [3:0] ALU_OR    = 4'd3;
    localparam logic [3:0] ALU_XOR   = 4'd4;
    localparam logic [3:0] ALU_SLT   = 4'd5;
    localparam logic [3:0] ALU_SLTU  = 4'd6;
    localparam logic [3:0] ALU_SLL   = 4'd7;
    localparam logic [3:0] ALU_SRL   = 4'd8;
    localparam logic [3:0] ALU_SRA   = 4'd9;
    localparam logic [3:0] ALU_PASSB = 4'd10;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'd0,
        ALUOP_SUB   = 2'd1,
        ALUOP_FUNCT = 2'd2,
        ALUOP_PASSB = 2'd3
    } alu_op_t;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2   = 2'b00;
    localparam logic [1:0] SRCB_IMM   = 2'b01;
    localparam logic [1:0] SRCB_FOUR  = 2'b10;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_RDATA  = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    // funct3 010/011 never reach BRANCH (rejected in DECODE), so they map to 0.
    function automatic logic branch_taken(input logic [2:0] f3, input logic zero,
                                          input logic lt, input logic ltu);
        logic taken;
        case (f3)
            3'b000:  taken = zero;
            3'b001:  taken = !zero;
            3'b100:  taken = lt;
            3'b101:  taken = !lt;
            3'b110:  taken = ltu;
            3'b111:  taken = !ltu;
            default: taken = 1'b0;
        endcase
        return taken;
    endfunction

endpackage

// File: rtl/multicycle_control_fsm_alu_decoder.sv
// alu_decoder: combinational ALU operation decode.
// Ports:
//   alu_op       in  ALU-op class chosen by the FSM (ADD/SUB/FUNCT/PASSB)
//   funct3       in  instruction[14:12]
//   funct7_5     in  instruction[30]
//   opcode_5     in  instruction[5]; 1 = R-type, 0 = I-type
//   alu_control  out ALU operation code
module alu_decoder
    import control_pkg::*;
#(
    parameter int ALU_CTRL_W = 4
) (
    input  alu_op_t               alu_op,
    input  logic [2:0]            funct3,
    input  logic                  funct7_5,
    input  logic                  opcode_5,
    output logic [ALU_CTRL_W-1:0] alu_control
);

    logic [3:0] code;

    always_comb begin
        code = ALU_ADD;
        case (alu_op)
            ALUOP_ADD:   code = ALU_ADD;
            ALUOP_SUB:   code = ALU_SUB;
            ALUOP_PASSB: code = ALU_PASSB;
            ALUOP_FUNCT: begin
                case (funct3)
                    // instruction[30] is immediate data for ADDI, so SUB only for R-type
                    3'b000:  code = (opcode_5 && funct7_5) ? ALU_SUB : ALU_ADD;
                    3'b001:  code = ALU_SLL;
                    3'b010:  code = ALU_SLT;
                    3'b011:  code = ALU_SLTU;
                    3'b100:  code = ALU_XOR;
                    3'b101:  code = funct7_5 ? ALU_SRA : ALU_SRL;
                    3'b110:  code = ALU_OR;
                    default: code = ALU_AND;
                endcase
            end
            default:     code = ALU_ADD;
        endcase
    end

    assign alu_control = ALU_CTRL_W'(code);

endmodule

// File: rtl/multicycle_control_fsm.sv
// multicycle_control_fsm: control FSM for the multicycle RV32I core.
// Sequences fetch/decode/execute/memory/writeback and drives every datapath
// select, write enable and ALU_control. Outputs are combinational from the
// state register, instruction fields and ALU flags.
// Ports:
//   clock, resetn        clock; asynchronous active-low reset (state -> FETCH)
//   opcode/funct3/funct7 instruction fields
//   zero/lt/ltu          ALU compare flags for branches
//   mem_ready            memory access completes this cycle
//   pc_write, ir_write, memory_write, register_write   write enables
//   address_source, result_source, ALU_source_A/B, immediate_source  selects
//   ALU_control          ALU operation
//   illegal_instr        pulse in DECODE on an unsupported encoding
//   state_out            current state (debug)
//
// state      | meaning
// 0  FETCH     | read instruction at PC, PC+4 -> PC when memory ready
// 1  DECODE    | oldPC+imm -> ALUOut (branch/JAL target), dispatch
// 2  MEMADR    | rs1+imm -> ALUOut
// 3  MEMREAD   | load from ALUOut, wait for mem_ready
// 4  MEMWB     | read data -> rd
// 5  MEMWRITE  | store to ALUOut, wait for mem_ready
// 6  EXEC_R    | rs1 op rs2
// 7  ALUWB     | ALUOut -> rd
// 8  EXEC_I    | rs1 op imm
// 9  JAL       | ALUOut -> PC, oldPC+4 -> ALUOut (link)
// 10 BRANCH    | rs1-rs2 compare, ALUOut -> PC if taken
// 11 EXEC_JALR | rs1+imm -> ALUOut
// 12 LUI       | imm -> ALUOut
// 13 AUIPC     | oldPC+imm -> ALUOut
module multicycle_control_fsm
    import control_pkg::*;
#(
    parameter int ALU_CTRL_W    = 4,
    parameter int MEM_HANDSHAKE = 1,
    parameter int SUPPORT_JALR  = 1
) (
    input  logic                  clock,
    input  logic                  resetn,
    input  logic [6:0]            opcode,
    input  logic [2:0]            funct3,
    input  logic [6:0]            funct7,
    input  logic                  zero,
    input  logic                  lt,
    input  logic                  ltu,
    input  logic                  mem_ready,
    output logic                  pc_write,
    output logic                  address_source,
    output logic                  memory_write,
    output logic                  ir_write,
    output logic                  register_write,
    output logic [1:0]            result_source,
    output logic [ALU_CTRL_W-1:0] ALU_control,
    output logic [1:0]            ALU_source_A,
    output logic [1:0]            ALU_source_B,
    output logic [2:0]            immediate_source,
    output logic                  illegal_instr,
    output logic [3:0]            state_out
);

    logic [3:0] state;
    logic [3:0] state_nxt;
    logic       ready;
    logic       pc_write_c;
    logic       memory_write_c;
    logic       ir_write_c;
    logic       register_write_c;
    logic       illegal_c;
    alu_op_t    alu_op;
    logic       unused_funct7;

    assign ready = (MEM_HANDSHAKE != 0) ? mem_ready : 1'b1;
    assign unused_funct7 = ^{funct7[6], funct7[4:0]};

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state <= S_FETCH;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt        = S_FETCH;
        pc_write_c       = 1'b0;
        memory_write_c   = 1'b0;
        ir_write_c       = 1'b0;
        register_write_c = 1'b0;
        illegal_c        = 1'b0;
        address_source   = 1'b0;
        result_source    = RES_ALUOUT;
        ALU_source_A     = SRCA_PC;
        ALU_source_B     = SRCB_RS2;
        alu_op           = ALUOP_ADD;
        case (state)
            S_FETCH: begin
                ALU_source_A  = SRCA_PC;
                ALU_source_B  = SRCB_FOUR;
                result_source = RES_ALU;
                ir_write_c    = ready;
                pc_write_c    = ready;
                state_nxt     = ready ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                ALU_source_A = SRCA_OLDPC;
                ALU_source_B = SRCB_IMM;
                case (opcode)
                    OPC_LOAD, OPC_STORE: state_nxt = S_MEMADR;
                    OPC_OP:              state_nxt = S_EXEC_R;
                    OPC_OP_IMM:          state_nxt = S_EXEC_I;
                    OPC_JAL:             state_nxt = S_JAL;
                    OPC_LUI:             state_nxt = S_LUI;
                    OPC_AUIPC:           state_nxt = S_AUIPC;
                    OPC_JALR: begin
                        if (SUPPORT_JALR != 0) begin
                            state_nxt = S_EXEC_JALR;
                        end else begin
                            illegal_c = 1'b1;
                        end
                    end
                    OPC_BRANCH: begin
                        if (funct3[2:1] == 2'b01) begin
                            illegal_c = 1'b1;
                        end else begin
                            state_nxt = S_BRANCH;
                        end
                    end
                    default:             illegal_c = 1'b1;
                endcase
            end
            S_MEMADR: begin
                ALU_source_A = SRCA_RS1;
                ALU_source_B = SRCB_IMM;
                state_nxt    = opcode[5] ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                address_source = 1'b1;
                state_nxt      = ready ? S_MEMWB : S_MEMREAD;
            end
            S_MEMWB: begin
                result_source    = RES_RDATA;
                register_write_c = 1'b1;
            end
            S_MEMWRITE: begin
                address_source = 1'b1;
                memory_write_c = 1'b1;
                state_nxt      = ready ? S_FETCH : S_MEMWRITE;
            end
            S_EXEC_R: begin
                ALU_source_A = SRCA_RS1;
                ALU_source_B = SRCB_RS2;
                alu_op       = ALUOP_FUNCT;
                state_nxt    = S_ALUWB;
            end
            S_EXEC_I: begin
                ALU_source_A = SRCA_RS1;
                ALU_source_B = SRCB_IMM;
                alu_op       = ALUOP_FUNCT;
                state_nxt    = S_ALUWB;
            end
            S_EXEC_JALR: begin
                ALU_source_A = SRCA_RS1;
                ALU_source_B = SRCB_IMM;
                state_nxt    = S_JAL;
            end
            S_JAL: begin
                ALU_source_A  = SRCA_OLDPC;
                ALU_source_B  = SRCB_FOUR;
                result_source = RES_ALUOUT;
                pc_write_c    = 1'b1;
                state_nxt     = S_ALUWB;
            end
            S_LUI: begin
                ALU_source_B = SRCB_IMM;
                alu_op       = ALUOP_PASSB;
                state_nxt    = S_ALUWB;
            end
            S_AUIPC: begin
                ALU_source_A = SRCA_OLDPC;
                ALU_source_B = SRCB_IMM;
                state_nxt    = S_ALUWB;
            end
            S_ALUWB: begin
                result_source    = RES_ALUOUT;
                register_write_c = 1'b1;
            end
            S_BRANCH: begin
                ALU_source_A  = SRCA_RS1;
                ALU_source_B  = SRCB_RS2;
                alu_op        = ALUOP_SUB;
                result_source = RES_ALUOUT;
                pc_write_c    = branch_taken(funct3, zero, lt, ltu);
            end
            default: state_nxt = S_FETCH;
        endcase
    end

    always_comb begin
        case (opcode)
            OPC_STORE:            immediate_source = IMM_S;
            OPC_BRANCH:           immediate_source = IMM_B;
            OPC_JAL:              immediate_source = IMM_J;
            OPC_LUI, OPC_AUIPC:   immediate_source = IMM_U;
            default:              immediate_source = IMM_I;
        endcase
    end

    alu_decoder #(
        .ALU_CTRL_W (ALU_CTRL_W)
    ) u_alu_decoder (
        .alu_op      (alu_op),
        .funct3      (funct3),
        .funct7_5    (funct7[5]),
        .opcode_5    (opcode[5]),
        .alu_control (ALU_control)
    );

    // The state clears asynchronously, but FETCH's enables depend on mem_ready,
    // so every write enable is also gated directly by resetn.
    assign pc_write       = resetn & pc_write_c;
    assign ir_write       = resetn & ir_write_c;
    assign memory_write   = resetn & memory_write_c;
    assign register_write = resetn & register_write_c;
    assign illegal_instr  = resetn & illegal_c;
    assign state_out      = state;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
module tb_multicycle_control_fsm;

    logic       clock;
    logic       resetn;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       zero, lt, ltu, mem_ready;

    logic       pc_write, address_source, memory_write, ir_write, register_write;
    logic [1:0] result_source, ALU_source_A, ALU_source_B;
    logic [3:0] ALU_control;
    logic [2:0] immediate_source;
    logic       illegal_instr;
    logic [3:0] state_out;

    logic       n_pc_write, n_address_source, n_memory_write, n_ir_write, n_register_write;
    logic [1:0] n_result_source, n_ALU_source_A, n_ALU_source_B;
    logic [3:0] n_ALU_control;
    logic [2:0] n_immediate_source;
    logic       n_illegal_instr;
    logic [3:0] n_state_out;

    int tests = 0;
    int fails = 0;

    multicycle_control_fsm #(.ALU_CTRL_W(4), .MEM_HANDSHAKE(1), .SUPPORT_JALR(1)) u_dut (
        .clock(clock), .resetn(resetn), .opcode(opcode), .funct3(funct3), .funct7(funct7),
        .zero(zero), .lt(lt), .ltu(ltu), .mem_ready(mem_ready),
        .pc_write(pc_write), .address_source(address_source), .memory_write(memory_write),
        .ir_write(ir_write), .register_write(register_write), .result_source(result_source),
        .ALU_control(ALU_control), .ALU_source_A(ALU_source_A), .ALU_source_B(ALU_source_B),
        .immediate_source(immediate_source), .illegal_instr(illegal_instr), .state_out(state_out)
    );

    multicycle_control_fsm #(.ALU_CTRL_W(4), .MEM_HANDSHAKE(1), .SUPPORT_JALR(0)) u_nojalr (
        .clock(clock), .resetn(resetn), .opcode(opcode), .funct3(funct3), .funct7(funct7),
        .zero(zero), .lt(lt), .ltu(ltu), .mem_ready(mem_ready),
        .pc_write(n_pc_write), .address_source(n_address_source), .memory_write(n_memory_write),
        .ir_write(n_ir_write), .register_write(n_register_write), .result_source(n_result_source),
        .ALU_control(n_ALU_control), .ALU_source_A(n_ALU_source_A), .ALU_source_B(n_ALU_source_B),
        .immediate_source(n_immediate_source), .illegal_instr(n_illegal_instr), .state_out(n_state_out)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic set_instr(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7);
        opcode = op;
        funct3 = f3;
        funct7 = f7;
    endtask

    // {funct3, zero, lt, ltu, expected pc_write}
    logic [6:0] br_vec [5];
    logic [6:0] bv;

    initial begin
        br_vec[0] = {3'd1, 1'b0, 1'b0, 1'b0, 1'b1};   // BNE, zero=0 -> taken
        br_vec[1] = {3'd1, 1'b1, 1'b0, 1'b0, 1'b0};   // BNE, zero=1 -> not taken
        br_vec[2] = {3'd6, 1'b0, 1'b0, 1'b1, 1'b1};   // BLTU, ltu=1 -> taken
        br_vec[3] = {3'd5, 1'b0, 1'b1, 1'b0, 1'b0};   // BGE, lt=1 -> not taken
        br_vec[4] = {3'd0, 1'b1, 1'b0, 1'b0, 1'b1};   // BEQ, zero=1 -> taken

        resetn = 1'b0; mem_ready = 1'b1; zero = 1'b0; lt = 1'b0; ltu = 1'b0;
        set_instr(7'h33, 3'd0, 7'h20);
        #1;
        chk("rst_state", {4'd0, state_out}, 8'd0);
        chk("rst_ir_write", {7'd0, ir_write}, 8'd0);
        chk("rst_pc_write", {7'd0, pc_write}, 8'd0);
        chk("rst_srcb", {6'd0, ALU_source_B}, 8'd2);
        chk("rst_result_src", {6'd0, result_source}, 8'd2);

        // SUB: 0 -> 1 -> 6 -> 7 -> 0
        step; resetn = 1'b1; #1;
        chk("sub_fetch_ir", {7'd0, ir_write}, 8'd1);
        chk("sub_fetch_pc", {7'd0, pc_write}, 8'd1);
        step;
        chk("sub_dec_state", {4'd0, state_out}, 8'd1);
        chk("sub_dec_srca", {6'd0, ALU_source_A}, 8'd1);
        chk("sub_dec_srcb", {6'd0, ALU_source_B}, 8'd1);
        step;
        chk("sub_exec_state", {4'd0, state_out}, 8'd6);
        chk("sub_exec_alu", {4'd0, ALU_control}, 8'd1);
        chk("sub_exec_regw", {7'd0, register_write}, 8'd0);
        step;
        chk("sub_wb_state", {4'd0, state_out}, 8'd7);
        chk("sub_wb_regw", {7'd0, register_write}, 8'd1);
        step;
        chk("sub_done_state", {4'd0, state_out}, 8'd0);
        chk("sub_done_regw", {7'd0, register_write}, 8'd0);

        // SRAI and ADDI with instruction[30] set
        set_instr(7'h13, 3'd5, 7'h20);
        step; step;
        chk("srai_state", {4'd0, state_out}, 8'd8);
        chk("srai_alu", {4'd0, ALU_control}, 8'd9);
        step; step;
        set_instr(7'h13, 3'd0, 7'h20);
        step; step;
        chk("addi_alu", {4'd0, ALU_control}, 8'd0);
        step; step;
        chk("addi_done_state", {4'd0, state_out}, 8'd0);

        // LW with 3 wait cycles in MEMREAD
        set_instr(7'h03, 3'd2, 7'h00);
        step;
        chk("lw_imm_src", {5'd0, immediate_source}, 8'd0);
        step;
        chk("lw_memadr_state", {4'd0, state_out}, 8'd2);
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step;
            chk("lw_memread_wait", {4'd0, state_out}, 8'd3);
            chk("lw_memread_addr", {7'd0, address_source}, 8'd1);
        end
        mem_ready = 1'b1; #1;
        chk("lw_memread_last", {4'd0, state_out}, 8'd3);
        step;
        chk("lw_memwb_state", {4'd0, state_out}, 8'd4);
        chk("lw_memwb_regw", {7'd0, register_write}, 8'd1);
        chk("lw_memwb_res", {6'd0, result_source}, 8'd1);
        step;
        chk("lw_done_regw", {7'd0, register_write}, 8'd0);

        // SW with one wait cycle
        set_instr(7'h23, 3'd2, 7'h00);
        step;
        chk("sw_imm_src", {5'd0, immediate_source}, 8'd1);
        step; mem_ready = 1'b0;
        step;
        chk("sw_memwrite_state", {4'd0, state_out}, 8'd5);
        chk("sw_memwrite_we", {7'd0, memory_write}, 8'd1);
        mem_ready = 1'b1; #1;
        chk("sw_memwrite_last_we", {7'd0, memory_write}, 8'd1);
        step;
        chk("sw_done_state", {4'd0, state_out}, 8'd0);
        chk("sw_done_we", {7'd0, memory_write}, 8'd0);

        // Branch conditions
        for (int i = 0; i < 5; i++) begin
            bv = br_vec[i];
            set_instr(7'h63, bv[6:4], 7'h00);
            zero = bv[3]; lt = bv[2]; ltu = bv[1];
            step;
            chk("br_imm_src", {5'd0, immediate_source}, 8'd2);
            step;
            chk("br_state", {4'd0, state_out}, 8'd10);
            chk("br_pc_write", {7'd0, pc_write}, {7'd0, bv[0]});
            chk("br_alu", {4'd0, ALU_control}, 8'd1);
            step;
            chk("br_done_state", {4'd0, state_out}, 8'd0);
        end
        zero = 1'b0; lt = 1'b0; ltu = 1'b0;

        // Branch funct3 010 is illegal
        set_instr(7'h63, 3'd2, 7'h00);
        step;
        chk("br010_illegal", {7'd0, illegal_instr}, 8'd1);
        step;
        chk("br010_state", {4'd0, state_out}, 8'd0);

        // JALR: 0 -> 1 -> 11 -> 9 -> 7 -> 0; illegal when not supported
        set_instr(7'h67, 3'd0, 7'h00);
        step;
        chk("jalr_illegal", {7'd0, illegal_instr}, 8'd0);
        chk("nojalr_dec_state", {4'd0, n_state_out}, 8'd1);
        chk("nojalr_illegal", {7'd0, n_illegal_instr}, 8'd1);
        step;
        chk("jalr_exec_state", {4'd0, state_out}, 8'd11);
        chk("jalr_exec_pcw", {7'd0, pc_write}, 8'd0);
        chk("nojalr_back_state", {4'd0, n_state_out}, 8'd0);
        chk("nojalr_illegal_end", {7'd0, n_illegal_instr}, 8'd0);
        step;
        chk("jalr_jal_state", {4'd0, state_out}, 8'd9);
        chk("jalr_jal_pcw", {7'd0, pc_write}, 8'd1);
        step;
        chk("jalr_wb_state", {4'd0, state_out}, 8'd7);
        chk("jalr_wb_pcw", {7'd0, pc_write}, 8'd0);
        chk("jalr_wb_regw", {7'd0, register_write}, 8'd1);
        step;
        chk("jalr_done_state", {4'd0, state_out}, 8'd0);

        // LUI and AUIPC
        set_instr(7'h37, 3'd0, 7'h00);
        step;
        chk("lui_imm_src", {5'd0, immediate_source}, 8'd4);
        step;
        chk("lui_state", {4'd0, state_out}, 8'd12);
        chk("lui_alu", {4'd0, ALU_control}, 8'd10);
        step; step;
        set_instr(7'h17, 3'd0, 7'h00);
        step; step;
        chk("auipc_state", {4'd0, state_out}, 8'd13);
        chk("auipc_srca", {6'd0, ALU_source_A}, 8'd1);
        step; step;

        // Unsupported opcode
        set_instr(7'h7f, 3'd0, 7'h00);
        step;
        chk("ill_illegal", {7'd0, illegal_instr}, 8'd1);
        chk("ill_regw", {7'd0, register_write}, 8'd0);
        chk("ill_memw", {7'd0, memory_write}, 8'd0);
        step;
        chk("ill_back_state", {4'd0, state_out}, 8'd0);
        chk("ill_pulse_end", {7'd0, illegal_instr}, 8'd0);

        // Reset during MEMWRITE
        set_instr(7'h23, 3'd0, 7'h00);
        step; step; mem_ready = 1'b0;
        step;
        chk("rstmw_we", {7'd0, memory_write}, 8'd1);
        step;
        chk("rstmw_state", {4'd0, state_out}, 8'd5);
        #2; resetn = 1'b0; #1;
        chk("rstmw_we_drop", {7'd0, memory_write}, 8'd0);
        chk("rstmw_state_clr", {4'd0, state_out}, 8'd0);
        step; resetn = 1'b1; #1;
        chk("rstmw_ir_wait", {7'd0, ir_write}, 8'd0);
        step;
        chk("rstmw_fetch_hold", {4'd0, state_out}, 8'd0);
        mem_ready = 1'b1; #1;
        chk("rstmw_ir_ready", {7'd0, ir_write}, 8'd1);
        step;
        chk("rstmw_decode", {4'd0, state_out}, 8'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/multicycle_control_fsm.md
Name: multicycle_control_fsm

Overview:
Parametrised control FSM for the multicycle RV32I core.
- Sequences fetch/decode/execute/memory/writeback.
- Drives all datapath mux selects and write enables, and ALU_control.
- Generalises the core's earlier control block: full RV32I ALU ops, all six branch conditions, JALR/LUI/AUIPC.
- Adds a memory-ready handshake with wait states and an illegal-instruction flag.

Parameters:
ALU_CTRL_W, 4, width of ALU_control.
MEM_HANDSHAKE, 1, 1 = memory states wait for mem_ready; 0 = mem_ready treated as constant 1.
SUPPORT_JALR, 1, 0 = JALR opcode decoded as illegal.

Ports:
clock  in  1  system clock
resetn  in  1  reset, asynchronous, active-low
opcode  in  7  instruction[6:0]
funct3  in  3  instruction[14:12]
funct7  in  7  instruction[31:25]
zero  in  1  ALU result == 0
lt  in  1  signed rs1 < rs2 (from ALU)
ltu  in  1  unsigned rs1 < rs2
mem_ready  in  1  memory access completes this cycle
pc_write  out  1  PC load enable
address_source  out  1  0 = PC, 1 = ALUOut
memory_write  out  1  store enable
ir_write  out  1  IR / oldPC load enable
register_write  out  1  register file write enable
result_source  out  2  00 ALUOut, 01 read data, 10 ALU result
ALU_control  out  ALU_CTRL_W  ALU operation
ALU_source_A  out  2  00 PC, 01 oldPC, 10 rs1
ALU_source_B  out  2  00 rs2, 01 imm, 10 const 4
immediate_source  out  3  000 I, 001 S, 010 B, 011 J, 100 U
illegal_instr  out  1  one-cycle pulse in DECODE on an unsupported encoding
state_out  out  4  current state, debug only

Behaviour:
- Reset and output style:
  - Single state register; asynchronous clear to FETCH on resetn low.
  - All outputs are combinational from state, opcode, funct fields and flags.
  - While resetn = 0: pc_write, ir_write, memory_write, register_write and illegal_instr are forced 0; the other outputs take FETCH values.
  - A reset mid-access aborts it; no partial write is permitted.
- Unlisted outputs in every state: write enables 0, selects 00, ALU op ADD.
- immediate_source decodes from opcode in every state: load/OP-IMM/JALR -> I, store -> S, branch -> B, JAL -> J, LUI/AUIPC -> U.
- ALU_control codes: ADD 0, SUB 1, AND 2, OR 3, XOR 4, SLT 5, SLTU 6, SLL 7, SRL 8, SRA 9, PASSB 10.
- ALU_control decode, in EXEC_R / EXEC_I:
  - funct3 selects the op.
  - funct3 000 gives SUB only for R-type with funct7[5] = 1; I-type is always ADD.
  - funct3 101 with funct7[5] = 1 gives SRA.
- States (4-bit) and transitions:
  - FETCH: address_source 0, A=PC, B=4, ADD, result_source 10. ir_write and pc_write assert only when mem_ready = 1; the state is held otherwise. -> DECODE.
  - DECODE: A=oldPC, B=imm, ADD (precomputes branch/JAL target into ALUOut).
    - load/store -> MEMADR; OP -> EXEC_R; OP-IMM -> EXEC_I; JAL -> JAL; JALR -> EXEC_JALR.
    - branch -> BRANCH; LUI -> LUI; AUIPC -> AUIPC.
    - Any other encoding: illegal_instr = 1, -> FETCH.
  - MEMADR: A=rs1, B=imm, ADD. Load -> MEMREAD; store -> MEMWRITE.
  - MEMREAD: address_source 1. Held until mem_ready; then -> MEMWB.
  - MEMWB: result_source 01, register_write 1. -> FETCH.
  - MEMWRITE: address_source 1; memory_write held high every cycle until mem_ready = 1 inclusive. -> FETCH.
  - EXEC_R: A=rs1, B=rs2, decoded op. -> ALUWB.
  - EXEC_I: A=rs1, B=imm, decoded op. -> ALUWB.
  - EXEC_JALR: A=rs1, B=imm, ADD. -> JAL. The datapath clears PC bit 0.
  - JAL: A=oldPC, B=4, ADD, result_source 00, pc_write 1. -> ALUWB.
  - LUI: B=imm, PASSB. -> ALUWB.
  - AUIPC: A=oldPC, B=imm, ADD. -> ALUWB.
  - ALUWB: result_source 00, register_write 1. -> FETCH.
  - BRANCH: A=rs1, B=rs2, SUB, result_source 00. -> FETCH.
    - pc_write = taken, where taken is: 000 zero, 001 !zero, 100 lt, 101 !lt, 110 ltu, 111 !ltu.
    - funct3 010/011 is flagged illegal in DECODE and returns to FETCH.
- Unreachable state codes -> FETCH.

Decomposition:
- Package control_pkg holds: state encodings, opcode constants, ALU_control codes, and source/result/immediate select codes.
- One sub-module: alu_decoder, combinational. Inputs: alu_op class, funct3, funct7[5], opcode[5]. Output: ALU_control.

Test Plan:
- Reset with resetn low during MEMWRITE -> memory_write drops to 0 the same cycle; state_out = 0 after release; next ir_write occurs only on mem_ready.
- SUB (opcode 0x33, funct3 0, funct7 0x20), mem_ready = 1 -> states 0,1,6,7; ALU_control = 1 in EXEC_R; register_write = 1 for exactly one cycle.
- LW with mem_ready low for 3 cycles in MEMREAD -> MEMREAD lasts 4 cycles; MEMWB register_write is a single pulse.
- BNE (opcode 0x63, funct3 1): zero = 0 -> pc_write = 1 in BRANCH; zero = 1 -> pc_write = 0. Repeat for BLTU with ltu = 1 -> pc_write = 1.
- JALR (opcode 0x67) -> states 0,1,11,9,7; pc_write in JAL only. With SUPPORT_JALR = 0 -> illegal_instr pulse, back to FETCH.
- Opcode 0x7F -> illegal_instr = 1 for one DECODE cycle, then FETCH; no register_write or memory_write observed.
